instr_loader: RTL

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader_pkg.sv | 52 +++++
 rtl/instr_loader_if.sv | 41 ++++
 rtl/instr_loader_pack.sv | 32 +++
 rtl/instr_loader.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/instr_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_loader_pkg
//  Description : Shared constants and types for the instruction loader:
//                op codes, instruction field bit positions, FSM state enum.
//  Revision    : 1.0 - initial release
// ============================================================================
package instr_loader_pkg;

    // Op codes carried in the op field
    localparam logic [1:0] OP_DP      = 2'd0;
    localparam logic [1:0] OP_MEM     = 2'd1;
    localparam logic [1:0] OP_BR      = 2'd2;
    localparam logic [1:0] OP_ILLEGAL = 2'd3;

    // Field widths
    localparam int COND_W  = 4;
    localparam int OP_W    = 2;
    localparam int FUNCT_W = 6;
    localparam int RN_W    = 4;
    localparam int RD_W    = 4;
    localparam int SRC2_W  = 12;
    localparam int WORD_W  = 32;

    // Field bit positions inside the 32-bit instruction word
    localparam int COND_MSB  = 31;
    localparam int COND_LSB  = 28;
    localparam int OP_MSB    = 27;
    localparam int OP_LSB    = 26;
    localparam int FUNCT_MSB = 25;
    localparam int FUNCT_LSB = 20;
    localparam int RN_MSB    = 19;
    localparam int RN_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 12;
    localparam int SRC2_MSB  = 11;
    localparam int SRC2_LSB  = 0;

    // Loader session states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // True for the op value that must never be written to memory
    function automatic logic is_illegal_op(input logic [OP_W-1:0] op);
        return (op == OP_ILLEGAL);
    endfunction

endpackage : instr_loader_pkg
`default_nettype wire

// File: rtl/instr_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_loader_if
//  Description : Instruction-field handshake and instruction-memory write
//                bus between a field producer and the instruction loader.
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_loader_if #(
    parameter int AW = 6
) ();
    import instr_loader_pkg::*;

    // Field handshake
    logic                 in_valid;
    logic                 in_ready;
    logic [COND_W-1:0]    in_cond;
    logic [OP_W-1:0]      in_op;
    logic [FUNCT_W-1:0]   in_funct;
    logic [RN_W-1:0]      in_rn;
    logic [RD_W-1:0]      in_rd;
    logic [SRC2_W-1:0]    in_src2;

    // Instruction-memory write port
    logic                 mem_we;
    logic [AW-1:0]        mem_addr;
    logic [WORD_W-1:0]    mem_wdata;

    // Producer side: drives fields, observes ready and the memory writes
    modport master (
        output in_valid, in_cond, in_op, in_funct, in_rn, in_rd, in_src2,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    // Loader side
    modport slave (
        input  in_valid, in_cond, in_op, in_funct, in_rn, in_rd, in_src2,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

endinterface : instr_loader_if
`default_nettype wire

// File: rtl/instr_loader_pack.sv
`default_nettype none
// ============================================================================
//  Module      : instr_pack
//  Description : Combinational packing of instruction fields into the
//                32-bit instruction word.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_pack
    import instr_loader_pkg::*;
(
    input  wire logic [COND_W-1:0]  cond,
    input  wire logic [OP_W-1:0]    op,
    input  wire logic [FUNCT_W-1:0] funct,
    input  wire logic [RN_W-1:0]    rn,
    input  wire logic [RD_W-1:0]    rd,
    input  wire logic [SRC2_W-1:0]  src2,
    output logic      [WORD_W-1:0]  word
);

    // Place each field at its fixed bit position
    always_comb begin
        word                     = '0;
        word[COND_MSB:COND_LSB]   = cond;
        word[OP_MSB:OP_LSB]       = op;
        word[FUNCT_MSB:FUNCT_LSB] = funct;
        word[RN_MSB:RN_LSB]       = rn;
        word[RD_MSB:RD_LSB]       = rd;
        word[SRC2_MSB:SRC2_LSB]   = src2;
    end

endmodule : instr_pack
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
//  Module      : instr_loader
//  Description : Loads a session of 'count' encoded instructions into the
//                instruction memory starting at 'base_addr'. Illegal ops
//                are dropped and flagged on a sticky error bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int AW = 6
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          start,
    input  wire logic [AW-1:0] base_addr,
    input  wire logic [AW:0]   count,
    instr_loader_if.slave      bus,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam logic [AW:0] c_rem_last = {{AW{1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_state_nxt;
    logic [AW-1:0]       r_addr;
    logic [AW:0]         r_rem;
    logic                r_err;
    logic                r_we;
    logic [AW-1:0]       r_mem_addr;
    logic [WORD_W-1:0]   r_mem_wdata;

    logic                w_ready;
    logic                w_xfer;
    logic                w_legal;
    logic                w_start_ok;
    logic [WORD_W-1:0]   w_word;

    // Field packer
    instr_pack u_pack (
        .cond  (bus.in_cond),
        .op    (bus.in_op),
        .funct (bus.in_funct),
        .rn    (bus.in_rn),
        .rd    (bus.in_rd),
        .src2  (bus.in_src2),
        .word  (w_word)
    );

    assign w_xfer     = bus.in_valid && w_ready;
    assign w_legal    = !is_illegal_op(bus.in_op);
    assign w_start_ok = (r_state == ST_IDLE) && start;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: the last legal transfer moves straight to DONE so
    // that done coincides with the final write strobe
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (count != '0) ? ST_LOAD : ST_DONE;
                end
            end
            ST_LOAD: begin
                if (w_xfer && w_legal && (r_rem == c_rem_last)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM outputs decoded from the current state
    always_comb begin
        w_ready = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (r_state)
            ST_LOAD: begin
                w_ready = (r_rem != '0);
                busy    = 1'b1;
            end
            ST_DONE: begin
                done    = 1'b1;
            end
            default: begin
                w_ready = 1'b0;
            end
        endcase
    end

    // Session address / remaining counter, captured on start and stepped on
    // every legal transfer; illegal transfers leave them untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_rem  <= '0;
        end else if (w_start_ok) begin
            r_addr <= base_addr;
            r_rem  <= count;
        end else if (w_xfer && w_legal) begin
            r_addr <= r_addr + 1'b1;
            r_rem  <= r_rem - 1'b1;
        end
    end

    // Sticky illegal-op flag, cleared only when a new session starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_start_ok) begin
            r_err <= 1'b0;
        end else if (w_xfer && !w_legal) begin
            r_err <= 1'b1;
        end
    end

    // Registered memory write port; address and data hold between writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we        <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_we <= 1'b0;
            if (w_xfer && w_legal) begin
                r_we        <= 1'b1;
                r_mem_addr  <= r_addr;
                r_mem_wdata <= w_word;
            end
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.mem_we    = r_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign err           = r_err;

endmodule : instr_loader
`default_nettype wire
